// File: rtl/sequential_multiplier_if.sv
// Request/response bundle for the iterative shift-add multiplier.
// The controller drives the i_* side; the multiplier drives the o_* side.
interface sequential_multiplier_if #(
    parameter int BITS = 8
);
    logic                i_start;
    logic                i_signed;
    logic [BITS-1:0]     i_multiplier;
    logic [BITS-1:0]     i_multiplicand;
    logic                o_busy;
    logic                o_finished;
    logic [2*BITS-1:0]   o_product;

    modport master (
        output i_start,
        output i_signed,
        output i_multiplier,
        output i_multiplicand,
        input  o_busy,
        input  o_finished,
        input  o_product
    );

    modport slave (
        input  i_start,
        input  i_signed,
        input  i_multiplier,
        input  i_multiplicand,
        output o_busy,
        output o_finished,
        output o_product
    );
endinterface

// File: rtl/sequential_multiplier.sv
// Iterative shift-add multiplier: one partial product per clock, BITS clocks.
// Signed mode multiplies magnitudes and negates the result at the end.
module sequential_multiplier #(
    parameter int BITS = 8
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    sequential_multiplier_if.slave   bus
);
    localparam int PW = 2 * BITS;
    localparam int CW = $clog2(BITS);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [BITS-1:0] mplier;
    logic [PW-1:0]   mcand;
    logic [PW-1:0]   acc;
    logic [CW-1:0]   count;
    logic            negate;
    logic [PW-1:0]   product;
    logic            finished;
    logic            busy;

    logic            accept;
    logic            last;
    logic            a_neg;
    logic            b_neg;
    logic [BITS-1:0] mag_a;
    logic [BITS-1:0] mag_b;
    logic [PW-1:0]   partial;
    logic [PW-1:0]   acc_sum;

    // Operand magnitudes; |-2^(BITS-1)| still fits as an unsigned BITS value.
    always_comb begin
        a_neg = bus.i_signed & bus.i_multiplier[BITS-1];
        b_neg = bus.i_signed & bus.i_multiplicand[BITS-1];
        mag_a = a_neg ? -bus.i_multiplier : bus.i_multiplier;
        mag_b = b_neg ? -bus.i_multiplicand : bus.i_multiplicand;
    end

    // Handshake qualifiers and the current shift-add step.
    always_comb begin
        accept  = (state == IDLE) && bus.i_start;
        last    = (state == RUN) && (count == CW'(BITS - 1));
        partial = mplier[0] ? mcand : '0;
        acc_sum = acc + partial;
    end

    // State register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start launches a run, the last iteration ends it.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (accept) state_next = RUN;
            RUN:  if (last)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode from state.
    always_comb begin
        busy = 1'b0;
        unique case (state)
            IDLE: busy = 1'b0;
            RUN:  busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // Datapath: latch operands on accept, one shift-add per RUN cycle,
    // publish the signed-corrected product on the final iteration.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            mplier   <= '0;
            mcand    <= '0;
            acc      <= '0;
            count    <= '0;
            negate   <= 1'b0;
            product  <= '0;
            finished <= 1'b0;
        end else begin
            finished <= 1'b0;
            if (accept) begin
                mplier <= mag_a;
                mcand  <= {{BITS{1'b0}}, mag_b};
                acc    <= '0;
                count  <= '0;
                negate <= a_neg ^ b_neg;
            end else if (state == RUN) begin
                acc    <= acc_sum;
                mplier <= mplier >> 1;
                mcand  <= mcand << 1;
                count  <= count + CW'(1);
                if (last) begin
                    product  <= negate ? -acc_sum : acc_sum;
                    finished <= 1'b1;
                end
            end
        end
    end

    assign bus.o_busy     = busy;
    assign bus.o_finished = finished;
    assign bus.o_product  = product;
endmodule

// File: tb/tb_sequential_multiplier.sv
// Self-checking bench for sequential_multiplier at BITS = 8, 16 and 4.
// Directed vector table, hand-written corner sequences and random ops.
module tb_sequential_multiplier;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    sequential_multiplier_if #(.BITS(8))  b8 ();
    sequential_multiplier_if #(.BITS(16)) b16 ();
    sequential_multiplier_if #(.BITS(4))  b4 ();

    sequential_multiplier #(.BITS(8)) dut8 (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (b8)
    );
    sequential_multiplier #(.BITS(16)) dut16 (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (b16)
    );
    sequential_multiplier #(.BITS(4)) dut4 (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (b4)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        s;
        logic [15:0] p;
        string       name;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: exact integer product, truncated to the product width.
    function automatic logic [15:0] model8(input logic [7:0] a,
                                           input logic [7:0] b,
                                           input logic s);
        longint sa;
        longint sb;
        longint p;
        sa = s ? longint'($signed(a)) : longint'(a);
        sb = s ? longint'($signed(b)) : longint'(b);
        p  = sa * sb;
        return p[15:0];
    endfunction

    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic [15:0] exp,
                        input string name);
        int n;
        @(negedge clk);
        b8.i_start = 1'b1;
        b8.i_signed = s;
        b8.i_multiplier = a;
        b8.i_multiplicand = b;
        @(posedge clk);
        #1;
        b8.i_start = 1'b0;
        b8.i_multiplier = 8'($urandom);
        b8.i_multiplicand = 8'($urandom);
        b8.i_signed = 1'($urandom);
        check({name, " busy"}, 64'(b8.o_busy), 64'd1);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!b8.o_finished && n < 40);
        check({name, " latency"}, 64'(n), 64'd8);
        check({name, " product"}, 64'(b8.o_product), 64'(exp));
        check({name, " busy at finish"}, 64'(b8.o_busy), 64'd0);
        @(posedge clk);
        #1;
        check({name, " pulse width"}, 64'(b8.o_finished), 64'd0);
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic [31:0] exp,
                         input string name);
        int n;
        @(negedge clk);
        b16.i_start = 1'b1;
        b16.i_signed = s;
        b16.i_multiplier = a;
        b16.i_multiplicand = b;
        @(posedge clk);
        #1;
        b16.i_start = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!b16.o_finished && n < 60);
        check({name, " latency"}, 64'(n), 64'd16);
        check({name, " product"}, 64'(b16.o_product), 64'(exp));
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b,
                        input logic s, input logic [7:0] exp,
                        input string name);
        int n;
        @(negedge clk);
        b4.i_start = 1'b1;
        b4.i_signed = s;
        b4.i_multiplier = a;
        b4.i_multiplicand = b;
        @(posedge clk);
        #1;
        b4.i_start = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!b4.o_finished && n < 30);
        check({name, " latency"}, 64'(n), 64'd4);
        check({name, " product"}, 64'(b4.o_product), 64'(exp));
    endtask

    initial begin
        int n;
        int pulses;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rs;

        vecs[0] = '{8'd13,  8'd11,  1'b0, 16'h008F, "u13x11"};
        vecs[1] = '{8'd255, 8'd255, 1'b0, 16'hFE01, "u255x255"};
        vecs[2] = '{8'd0,   8'd200, 1'b0, 16'h0000, "u0x200"};
        vecs[3] = '{8'hFD,  8'd5,   1'b1, 16'hFFF1, "s-3x5"};
        vecs[4] = '{8'h80,  8'h80,  1'b1, 16'h4000, "s-128x-128"};
        vecs[5] = '{8'h7F,  8'h80,  1'b1, 16'hC080, "s127x-128"};
        vecs[6] = '{8'hFF,  8'hFF,  1'b1, 16'h0001, "s-1x-1"};

        rst = 1'b1;
        b8.i_start = 1'b0;  b8.i_signed = 1'b0;
        b8.i_multiplier = '0;  b8.i_multiplicand = '0;
        b16.i_start = 1'b0; b16.i_signed = 1'b0;
        b16.i_multiplier = '0; b16.i_multiplicand = '0;
        b4.i_start = 1'b0;  b4.i_signed = 1'b0;
        b4.i_multiplier = '0;  b4.i_multiplicand = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 64'(b8.o_busy), 64'd0);
        check("reset finished", 64'(b8.o_finished), 64'd0);
        check("reset product", 64'(b8.o_product), 64'd0);
        check("reset16 product", 64'(b16.o_product), 64'd0);
        check("reset4 busy", 64'(b4.o_busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++)
            run8(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].p, vecs[i].name);

        for (int i = 0; i < 25; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom);
            run8(ra, rb, rs, model8(ra, rb, rs), "random");
        end

        // Start while busy is ignored.
        @(negedge clk);
        b8.i_start = 1'b1; b8.i_signed = 1'b0;
        b8.i_multiplier = 8'd6; b8.i_multiplicand = 8'd7;
        @(posedge clk);
        #1;
        b8.i_start = 1'b0;
        n = 0;
        do begin
            if (n == 2) begin
                b8.i_start = 1'b1;
                b8.i_multiplier = 8'd9;
                b8.i_multiplicand = 8'd9;
            end
            @(posedge clk);
            #1;
            n++;
            b8.i_start = 1'b0;
        end while (!b8.o_finished && n < 40);
        check("busy-start latency", 64'(n), 64'd8);
        check("busy-start product", 64'(b8.o_product), 64'h2A);
        pulses = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (b8.o_finished) pulses++;
        end
        check("busy-start extra pulse", 64'(pulses), 64'd0);
        check("busy-start idle", 64'(b8.o_busy), 64'd0);

        // Reset mid-operation discards the run.
        @(negedge clk);
        b8.i_start = 1'b1; b8.i_signed = 1'b0;
        b8.i_multiplier = 8'd100; b8.i_multiplicand = 8'd100;
        @(posedge clk);
        #1;
        b8.i_start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midreset busy", 64'(b8.o_busy), 64'd0);
        check("midreset finished", 64'(b8.o_finished), 64'd0);
        check("midreset product", 64'(b8.o_product), 64'd0);
        pulses = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (b8.o_finished) pulses++;
        end
        check("midreset pulse", 64'(pulses), 64'd0);
        run8(8'd2, 8'd3, 1'b0, 16'h0006, "after reset 2x3");

        // Back-to-back: new start in the finished cycle.
        @(negedge clk);
        b8.i_start = 1'b1; b8.i_signed = 1'b0;
        b8.i_multiplier = 8'd5; b8.i_multiplicand = 8'd5;
        @(posedge clk);
        #1;
        b8.i_start = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!b8.o_finished && n < 40);
        check("b2b first latency", 64'(n), 64'd8);
        check("b2b first product", 64'(b8.o_product), 64'h19);
        b8.i_start = 1'b1;
        b8.i_multiplier = 8'd7; b8.i_multiplicand = 8'd8;
        @(posedge clk);
        #1;
        b8.i_start = 1'b0;
        check("b2b accept busy", 64'(b8.o_busy), 64'd1);
        check("b2b accept finished", 64'(b8.o_finished), 64'd0);
        check("b2b product held", 64'(b8.o_product), 64'h19);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!b8.o_finished && n < 40);
        check("b2b second latency", 64'(n), 64'd8);
        check("b2b second product", 64'(b8.o_product), 64'h38);

        run16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "w16 max");
        run16(16'h8000, 16'h8000, 1'b1, 32'h40000000, "w16 min^2");
        run16(16'd1234, 16'd567, 1'b0, 32'd699678, "w16 1234x567");
        run16(16'hFFFD, 16'd5, 1'b1, 32'hFFFFFFF1, "w16 -3x5");

        run4(4'h8, 4'h8, 1'b1, 8'h40, "w4 -8x-8");
        run4(4'hF, 4'hF, 1'b0, 8'hE1, "w4 15x15");
        run4(4'hD, 4'h5, 1'b1, 8'hF1, "w4 -3x5");
        run4(4'h7, 4'h8, 1'b1, 8'hC8, "w4 7x-8");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end
endmodule
